// File: rtl/rsc_constituent_encoder_pkg.sv
// ---------------------------------------------------------------------------
// turbo_pkg
// Shared definitions for the turbo encoder constituent RSC encoders.
//   G0_OCT / G1_OCT : feedback / feedforward generator polynomials (octal)
//   MEM             : encoder memory (number of shift register stages)
//   enc_state_t     : constituent encoder FSM state encoding
//   tap_mask()      : converts a generator into a mask over s[2:0]
// ---------------------------------------------------------------------------
package turbo_pkg;

  localparam int G0_OCT = 'o13;  // 1 + D^2 + D^3, feedback
  localparam int G1_OCT = 'o15;  // 1 + D + D^3, parity
  localparam int MEM    = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ENC  = ST_ENC,
    TAIL = ST_TAIL
  } enc_state_t;

  // Generator bit MEM is the D^0 term; bits MEM-1..0 are D^1..D^MEM.
  // s[0] holds the newest stage (D^1) and s[MEM-1] the oldest (D^MEM),
  // so the mask over {s[2],s[1],s[0]} is the generator's low bits reversed.
  function automatic logic [MEM-1:0] tap_mask(input int g);
    logic [MEM-1:0] m;
    for (int i = 0; i < MEM; i++) begin
      m[i] = g[MEM-1-i];
    end
    return m;
  endfunction

endpackage

// File: rtl/rsc_constituent_encoder_if.sv
// ---------------------------------------------------------------------------
// rsc_constituent_encoder_if
// Byte input from the interleaver stage and bit/byte outputs towards the
// multiplexer/puncturer.
//   data_in, data_en                       : byte and its level-type enable
//   sys_bit, par_bit, bit_valid, tail_flag : per-cycle bit pair stream
//   parity_byte, done                      : data-phase parity byte, end pulse
//   busy, overrun                          : status
// master = interleaver/consumer side, slave = encoder.
// ---------------------------------------------------------------------------
interface rsc_constituent_encoder_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] data_in;
  logic              data_en;
  logic              sys_bit;
  logic              par_bit;
  logic              bit_valid;
  logic              tail_flag;
  logic [DATA_W-1:0] parity_byte;
  logic              done;
  logic              busy;
  logic              overrun;

  modport master (
    output data_in, data_en,
    input  sys_bit, par_bit, bit_valid, tail_flag, parity_byte, done, busy, overrun
  );

  modport slave (
    input  data_in, data_en,
    output sys_bit, par_bit, bit_valid, tail_flag, parity_byte, done, busy, overrun
  );

endinterface

// File: rtl/rsc_constituent_encoder_trellis.sv
// ---------------------------------------------------------------------------
// rsc_trellis_step
// One combinational trellis transition of the 8-state g0=13 / g1=15 RSC code.
//   u      : data input bit (ignored when tail=1)
//   s      : current state, s[0] newest stage
//   tail   : termination step, input is forced so that fb = 0
//   fb     : feedback bit shifted into s[0]
//   p      : parity output bit
//   u_eff  : systematic bit actually encoded (u, or the tail input)
//   s_next : next state {s[1], s[0], fb}
// ---------------------------------------------------------------------------
module rsc_trellis_step
  import turbo_pkg::*;
(
  input  logic           u,
  input  logic [MEM-1:0] s,
  input  logic           tail,
  output logic           fb,
  output logic           p,
  output logic           u_eff,
  output logic [MEM-1:0] s_next
);

  localparam logic [MEM-1:0] FB_MASK  = tap_mask(G0_OCT);
  localparam logic [MEM-1:0] PAR_MASK = tap_mask(G1_OCT);

  logic fb_state;

  assign fb_state = ^(s & FB_MASK);
  // During termination the input equals the state feedback, cancelling it.
  assign u_eff    = tail ? fb_state : u;
  assign fb       = u_eff ^ fb_state;
  assign p        = fb ^ (^(s & PAR_MASK));
  assign s_next   = {s[MEM-2:0], fb};

endmodule

// File: rtl/rsc_constituent_encoder.sv
// ---------------------------------------------------------------------------
// rsc_constituent_encoder
// Constituent RSC encoder of the turbo encoder. A rising edge on data_en
// captures data_in; the byte is serialised MSB first as DATA_W (sys, par)
// pairs followed by TAIL_N termination pairs. All outputs are registered.
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active-high
//   bus  : slave side of rsc_constituent_encoder_if
//
// state | meaning
// IDLE  | waiting for a data_en rising edge
// ENC   | emitting the DATA_W data-phase bit pairs
// TAIL  | emitting the TAIL_N termination pairs, done on the last one
// ---------------------------------------------------------------------------
module rsc_constituent_encoder
  import turbo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAIL_N = MEM
) (
  input  logic                         clk,
  input  logic                         rst,
  rsc_constituent_encoder_if.slave     bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  enc_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] shbuf, shbuf_n;
  logic [DATA_W-1:0] coll, coll_n;
  logic [MEM-1:0]    s, s_n;
  logic              en_q;
  logic              start;

  logic              sys_q, sys_n;
  logic              par_q, par_n;
  logic              valid_q, valid_n;
  logic              tail_q, tail_n;
  logic              done_q, done_n;
  logic              busy_q, busy_n;
  logic              ov_q, ov_n;
  logic [DATA_W-1:0] pbyte_q, pbyte_n;

  logic              step_p;
  logic              step_u_eff;
  logic [MEM-1:0]    step_s_next;
  logic              step_fb_unused;  // already present as step_s_next[0]

  assign start = bus.data_en & ~en_q;

  rsc_trellis_step u_step (
    .u      (shbuf[DATA_W-1]),
    .s      (s),
    .tail   (state == TAIL),
    .fb     (step_fb_unused),
    .p      (step_p),
    .u_eff  (step_u_eff),
    .s_next (step_s_next)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shbuf_n = shbuf;
    coll_n  = coll;
    s_n     = s;
    sys_n   = 1'b0;
    par_n   = 1'b0;
    valid_n = 1'b0;
    tail_n  = 1'b0;
    done_n  = 1'b0;
    pbyte_n = pbyte_q;
    // busy and overrun are judged on the current state so that an edge on
    // the final tail cycle is still an overrun, while the next one is accepted.
    busy_n  = (state != IDLE);
    ov_n    = start & (state != IDLE);

    unique case (state)
      IDLE: begin
        if (start) begin
          shbuf_n = bus.data_in;
          coll_n  = '0;
          s_n     = '0;
          cnt_n   = CNT_W'(DATA_W - 1);
          state_n = ENC;
        end
      end
      ENC: begin
        sys_n   = step_u_eff;
        par_n   = step_p;
        valid_n = 1'b1;
        s_n     = step_s_next;
        shbuf_n = {shbuf[DATA_W-2:0], 1'b0};
        coll_n  = {coll[DATA_W-2:0], step_p};
        if (cnt == '0) begin
          cnt_n   = CNT_W'(TAIL_N - 1);
          state_n = TAIL;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      TAIL: begin
        sys_n   = step_u_eff;
        par_n   = step_p;
        valid_n = 1'b1;
        tail_n  = 1'b1;
        s_n     = step_s_next;
        if (cnt == '0) begin
          done_n  = 1'b1;
          pbyte_n = coll;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shbuf   <= '0;
      coll    <= '0;
      s       <= '0;
      en_q    <= 1'b0;
      sys_q   <= 1'b0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      tail_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      pbyte_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shbuf   <= shbuf_n;
      coll    <= coll_n;
      s       <= s_n;
      en_q    <= bus.data_en;
      sys_q   <= sys_n;
      par_q   <= par_n;
      valid_q <= valid_n;
      tail_q  <= tail_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      ov_q    <= ov_n;
      pbyte_q <= pbyte_n;
    end
  end

  assign bus.sys_bit     = sys_q;
  assign bus.par_bit     = par_q;
  assign bus.bit_valid   = valid_q;
  assign bus.tail_flag   = tail_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = ov_q;
  assign bus.parity_byte = pbyte_q;

endmodule

// File: tb/tb_rsc_constituent_encoder.sv
// ---------------------------------------------------------------------------
// tb_rsc_constituent_encoder
// Directed bench for rsc_constituent_encoder with hand-computed vectors:
//   8'h80 -> parity 8'hF2, 8'h00 -> 8'h00, 8'hFF -> 8'hA3, 8'h01 -> 8'h01.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rsc_constituent_encoder;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  rsc_constituent_encoder_if #(.DATA_W(8)) enc_bus ();

  rsc_constituent_encoder #(.DATA_W(8), .TAIL_N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (enc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte with a 0->1 edge, return on the falling edge after the
  // sampling posedge (start cycle), where nothing must be emitted yet.
  task automatic raise_en(input logic [7:0] d);
    @(negedge clk);
    enc_bus.data_in = d;
    enc_bus.data_en = 1'b1;
    @(negedge clk);
    chk("start_no_valid", enc_bus.bit_valid, 1'b0);
    chk("start_no_busy", enc_bus.busy, 1'b0);
  endtask

  // Record the 11 bit pairs following a start and compare them. Sample i is
  // taken after the (i+1)-th posedge past the start. An extra edge can be
  // raised at sample raise_at (seen by the DUT on the next posedge).
  task automatic collect(input string tag, input logic [7:0] d, input logic [7:0] pexp,
                         input logic [2:0] tsys, input logic [2:0] tpar,
                         input int raise_at, input logic [7:0] raise_d,
                         input logic [10:0] ov_exp);
    logic [10:0] sv, pv, tv, vv, dv, bv, ov;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      sv[10-i] = enc_bus.sys_bit;
      pv[10-i] = enc_bus.par_bit;
      tv[10-i] = enc_bus.tail_flag;
      vv[10-i] = enc_bus.bit_valid;
      dv[10-i] = enc_bus.done;
      bv[10-i] = enc_bus.busy;
      ov[10-i] = enc_bus.overrun;
      if (i == raise_at) begin
        enc_bus.data_in = raise_d;
        enc_bus.data_en = 1'b1;
      end else if (raise_at >= 0 && raise_at < 10 && i == raise_at + 1) begin
        enc_bus.data_en = 1'b0;
      end
    end
    chk({tag, "_sys"},   sv, {d, tsys});
    chk({tag, "_par"},   pv, {pexp, tpar});
    chk({tag, "_tail"},  tv, 11'b000_0000_0111);
    chk({tag, "_valid"}, vv, 11'h7FF);
    chk({tag, "_done"},  dv, 11'b000_0000_0001);
    chk({tag, "_busy"},  bv, 11'h7FF);
    chk({tag, "_ovr"},   ov, ov_exp);
    chk({tag, "_pbyte"}, enc_bus.parity_byte, pexp);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    enc_bus.data_in = 8'h00;
    enc_bus.data_en = 1'b0;

    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {enc_bus.sys_bit, enc_bus.par_bit, enc_bus.bit_valid, enc_bus.tail_flag,
                       enc_bus.done, enc_bus.busy, enc_bus.overrun, enc_bus.parity_byte}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", enc_bus.bit_valid, 1'b0);

    // 2. 8'h80
    raise_en(8'h80);
    enc_bus.data_en = 1'b0;
    collect("b80", 8'h80, 8'hF2, 3'b011, 3'b101, -1, 8'h00, 11'h0);
    @(negedge clk);
    chk("b80_after_busy", enc_bus.busy, 1'b0);
    chk("b80_after_valid", enc_bus.bit_valid, 1'b0);
    @(negedge clk);
    chk("b80_pbyte_hold", enc_bus.parity_byte, 8'hF2);

    // 3. 8'h00 with data_en held high: only one byte encoded
    raise_en(8'h00);
    collect("b00", 8'h00, 8'h00, 3'b000, 3'b000, -1, 8'h00, 11'h0);
    repeat (3) @(negedge clk);
    chk("held_en_no_reencode", {enc_bus.bit_valid, enc_bus.busy}, 2'b00);
    enc_bus.data_en = 1'b0;

    // 4. overrun at start+4, first byte unaffected
    raise_en(8'h80);
    enc_bus.data_en = 1'b0;
    collect("ovr4", 8'h80, 8'hF2, 3'b011, 3'b101, 2, 8'h55, 11'b000_1000_0000);

    // 4b. edge coincident with done is an overrun and is dropped
    raise_en(8'hFF);
    enc_bus.data_en = 1'b0;
    collect("ovr_done", 8'hFF, 8'hA3, 3'b011, 3'b101, 9, 8'h3C, 11'b000_0000_0001);
    @(negedge clk);
    chk("ovr_done_drop1", enc_bus.bit_valid, 1'b0);
    @(negedge clk);
    chk("ovr_done_drop2", enc_bus.bit_valid, 1'b0);

    // 6. back-to-back: edge the cycle after done
    raise_en(8'h80);
    enc_bus.data_en = 1'b0;
    collect("b2b_a", 8'h80, 8'hF2, 3'b011, 3'b101, 10, 8'h01, 11'h0);
    @(negedge clk);
    chk("b2b_gap_valid", enc_bus.bit_valid, 1'b0);
    enc_bus.data_en = 1'b0;
    collect("b2b_b", 8'h01, 8'h01, 3'b011, 3'b101, -1, 8'h00, 11'h0);

    // 5. reset mid-operation
    raise_en(8'hFF);
    enc_bus.data_en = 1'b0;
    @(negedge clk);
    chk("rst_pair0", {enc_bus.sys_bit, enc_bus.par_bit, enc_bus.bit_valid}, 3'b111);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", enc_bus.bit_valid, 1'b0);
    chk("rst_busy", enc_bus.busy, 1'b0);
    chk("rst_pbyte", enc_bus.parity_byte, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_done", {enc_bus.done, enc_bus.bit_valid}, 2'b00);
    end
    raise_en(8'hFF);
    enc_bus.data_en = 1'b0;
    collect("post_rst", 8'hFF, 8'hA3, 3'b011, 3'b101, -1, 8'h00, 11'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
